// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Instruction fetch front end feeding the decode stage. It issues sequential
// requests to instruction memory over a req/ack handshake, buffers returned
// words with their PCs in a DEPTH-entry circular FIFO and presents the head
// to decode with a valid/ready handshake. A redirect flushes the FIFO,
// restarts fetch at redirect_pc and drops any stale in-flight response.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   imem_req / imem_addr     fetch request, held stable until imem_ack
//   imem_ack / imem_rdata    memory response, data sampled on ack only
//   redirect / redirect_pc   flush and restart fetch (highest priority)
//   out_valid / out_ready    decode handshake for the FIFO head
//   out_insn / out_pc        head instruction and its address (0 when empty)
// ----------------------------------------------------------------------------
module ifetch_queue #(
    parameter int IADDRWIDTH = 16,
    parameter int IWIDTH     = 16,
    parameter int DEPTH      = 4,
    parameter logic [IADDRWIDTH-1:0] RESET_PC = {IADDRWIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [IADDRWIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [IWIDTH-1:0]     imem_rdata,
    input  logic                  redirect,
    input  logic [IADDRWIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IWIDTH-1:0]     out_insn,
    output logic [IADDRWIDTH-1:0] out_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [PW-1:0]         PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
    localparam logic [IADDRWIDTH-1:0] ADDR_ONE = IADDRWIDTH'(1);

    // WAIT keeps the returning word, DISCARD drops it (redirected meanwhile)
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                  state_r;
    logic [IADDRWIDTH-1:0]   fetch_addr_r;
    logic                    req_r;
    logic [CW-1:0]           count_r;
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [IWIDTH-1:0]       insn_mem_r [DEPTH];
    logic [IADDRWIDTH-1:0]   pc_mem_r   [DEPTH];

    logic                    pop_s;
    logic                    push_s;
    logic [CW-1:0]           cnt_next_s;

    // Handshake decode and the occupancy the FIFO will have after this edge
    always_comb begin
        pop_s      = (count_r != CNT_ZERO) && out_ready;
        push_s     = (state_r == S_WAIT) && imem_ack && !redirect;
        cnt_next_s = count_r + CW'(push_s) - CW'(pop_s);
    end

    // Fetch FSM: request flag and fetch address move together with the state.
    // A request is only (re)issued when its result is guaranteed a FIFO slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            fetch_addr_r <= RESET_PC;
            req_r        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (redirect) begin
                        fetch_addr_r <= redirect_pc;
                        state_r      <= S_WAIT;
                        req_r        <= 1'b1;
                    end else if (count_r < DEPTH_C) begin
                        state_r      <= S_WAIT;
                        req_r        <= 1'b1;
                    end else begin
                        state_r      <= S_IDLE;
                        req_r        <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        // An ack this cycle retires the old request, so the
                        // new one starts clean; otherwise its data is stale.
                        fetch_addr_r <= redirect_pc;
                        state_r      <= imem_ack ? S_WAIT : S_DISCARD;
                        req_r        <= 1'b1;
                    end else if (imem_ack) begin
                        fetch_addr_r <= fetch_addr_r + ADDR_ONE;
                        if (cnt_next_s < DEPTH_C) begin
                            state_r <= S_WAIT;
                            req_r   <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                            req_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= S_WAIT;
                        req_r   <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (redirect) begin
                        fetch_addr_r <= redirect_pc;
                    end else begin
                        fetch_addr_r <= fetch_addr_r;
                    end
                    state_r <= imem_ack ? S_WAIT : S_DISCARD;
                    req_r   <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO bookkeeping: flush wins over any same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= CNT_ZERO;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else if (redirect) begin
            count_r  <= CNT_ZERO;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= cnt_next_s;
        end
    end

    // FIFO storage; contents are only observed while the entry is counted
    always_ff @(posedge clk) begin
        if (push_s) begin
            insn_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]   <= fetch_addr_r;
        end else begin
            insn_mem_r[wr_ptr_r] <= insn_mem_r[wr_ptr_r];
            pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
        end
    end

    // All outputs come straight from registers; head is forced to 0 when empty
    assign imem_req  = req_r;
    assign imem_addr = fetch_addr_r;
    assign out_valid = (count_r != CNT_ZERO);
    assign out_insn  = out_valid ? insn_mem_r[rd_ptr_r] : {IWIDTH{1'b0}};
    assign out_pc    = out_valid ? pc_mem_r[rd_ptr_r]   : {IADDRWIDTH{1'b0}};

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
// Self-checking bench for ifetch_queue: a directed vector table for the
// redirect corner cases, hand-written sequences for streaming, back-pressure,
// address wrap and asynchronous reset, and a randomized run compared against
// a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_insn;
    logic [15:0] out_pc;

    int errors = 0;
    int checks = 0;

    ifetch_queue #(
        .IADDRWIDTH(16),
        .IWIDTH    (16),
        .DEPTH     (DEPTH),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_insn   (out_insn),
        .out_pc     (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of {pc, insn}, one optional outstanding request
    // which may be marked stale, and the next fetch address.
    logic [31:0] m_q[$];
    logic        m_out;
    logic        m_stale;
    logic [15:0] m_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_addr  = 16'h0000;
    endtask

    task automatic model_update();
        int  pre;
        bit  do_pop;
        pre    = m_q.size();
        do_pop = (pre > 0) && out_ready;
        if (redirect) begin
            m_q.delete();
            m_stale = m_out && !imem_ack;
            m_out   = 1'b1;
            m_addr  = redirect_pc;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (m_out && imem_ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_q.push_back({m_addr, imem_rdata});
                    m_addr = m_addr + 16'd1;
                    m_out  = (m_q.size() < DEPTH);
                end
            end else if (!m_out) begin
                m_out = (pre < DEPTH);
            end
        end
    endtask

    task automatic check_model(input string name);
        logic [49:0] exp;
        logic [31:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 32'h0;
        exp  = {m_q.size() > 0, head[31:16], head[15:0], m_out, m_addr};
        chk(name, {14'h0, out_valid, out_pc, out_insn, imem_req, imem_addr}, {14'h0, exp});
    endtask

    // Apply inputs, take one clock edge, update the model, settle to negedge
    task automatic step(input logic r, input logic [15:0] rpc, input logic a,
                        input logic [15:0] rd, input logic rdy);
        redirect    = r;
        redirect_pc = rpc;
        imem_ack    = a;
        imem_rdata  = rd;
        out_ready   = rdy;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0;
        out_ready   = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("reset_state", {14'h0, out_valid, out_pc, out_insn, imem_req, imem_addr}, 64'h0);
    endtask

    typedef struct {
        logic        red;
        logic [15:0] rpc;
        logic        ack;
        logic [15:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_insn;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [15:0] rpc;

        // red, rpc, ack, rdata, rdy  ->  req, addr, valid, pc, insn
        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 16'hA000, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0000, 16'hA000};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 16'hA001, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA000};
        tbl[3]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0101, 1'b1, 16'h0100, 16'h1234};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b1, 16'h0102, 1'b1, 16'h0101, 16'h1111};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h0103, 1'b1, 16'h0101, 16'h1111};
        tbl[11] = '{1'b1, 16'h0200, 1'b1, 16'h3333, 1'b1, 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0000};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0000};

        do_reset();

        // Zero-wait streaming: one instruction per cycle after the first
        step(1'b0, 16'h0, 1'b1, mem_word(m_addr), 1'b1);
        chk("stream_first_req", {15'h0, imem_req, imem_addr, out_valid}, {15'h0, 1'b1, 16'h0000, 1'b0});
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 16'h0, 1'b1, mem_word(m_addr), 1'b1);
            chk("stream_pc", {out_valid, out_pc, out_insn},
                {1'b1, 16'(k), mem_word(16'(k))});
            check_model("stream_model");
        end

        // Back-pressure: exactly DEPTH entries fill, request drops
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 16'h0, 1'b1, mem_word(m_addr), 1'b0);
        chk("full_stall", {imem_req, imem_addr, out_valid, out_pc},
            {1'b0, 16'h0004, 1'b1, 16'h0000});
        for (int k = 1; k < 6; k++) begin
            step(1'b0, 16'h0, 1'b1, mem_word(m_addr), 1'b1);
            chk("drain_pc", {out_valid, out_pc}, {1'b1, 16'(k)});
            check_model("drain_model");
        end

        // Directed redirect vectors
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].red, tbl[i].rpc, tbl[i].ack, tbl[i].rdata, tbl[i].rdy);
            chk($sformatf("vec%0d", i),
                {15'h0, imem_req, imem_addr, out_valid, out_pc, out_insn},
                {15'h0, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_insn});
        end

        // Address wrap at the top of the address space
        do_reset();
        step(1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b1);
        chk("wrap_addr", {imem_req, imem_addr}, {1'b1, 16'hFFFE});
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0, 1'b1, mem_word(m_addr), 1'b1);
            chk("wrap_pc", {out_valid, out_pc}, {1'b1, 16'hFFFE + 16'(k)});
        end

        // Asynchronous reset mid-stream with three entries queued
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 1'b1, mem_word(m_addr), 1'b0);
        chk("pre_async_valid", {out_valid, imem_req}, {1'b1, 1'b1});
        #1 rst = 1'b1;
        #1 chk("async_reset", {out_valid, imem_req, imem_addr}, {1'b0, 1'b0, 16'h0000});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h0, 1'b1, mem_word(m_addr), 1'b1);
            check_model("restart_model");
        end
        chk("restart_pc", {out_valid, out_pc}, {1'b1, 16'h0001});

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                              : 16'($urandom);
            step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 7,
                 mem_word(m_addr), $urandom_range(0, 9) < 6);
            check_model("random_model");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
